// File: rtl/fetch_pkg.sv
// Shared types and constants for the MIPS32 instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  // sll $0,$0,0 doubles as the pipeline bubble.
  localparam logic [31:0] DEFAULT_NOP_INST = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] PC_ALIGN_MASK    = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, runs one req/gnt/rvalid transaction at a time and
// hands at most one instruction per cycle to decode, with redirect and stall handling.
import fetch_pkg::*;

// state | meaning
// REQ   | imem_req_o high at pc_q, waiting for grant
// WAIT  | request granted, waiting for rvalid (kill_q drops the response)
// HOLD  | word fetched while decode stalled, parked in the hold buffer
module fetch_stage #(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] NOP_INST = DEFAULT_NOP_INST
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_valid_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        valid_o
);

  fetch_state_t state_q;
  logic [31:0]  pc_q;
  logic         kill_q;
  logic [31:0]  hold_word_q;
  logic         hold_full_q;
  logic [31:0]  redirect_target;
  logic [31:0]  pc_next_seq;

  assign redirect_target = word_align(redirect_pc_i);
  assign pc_next_seq     = pc_q + PC_STEP;

  // Request is a pure decode of the state; gated so it stays low during reset.
  assign imem_req_o  = (state_q == REQ) && !rst;
  assign imem_addr_o = pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= REQ;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      hold_word_q <= '0;
      hold_full_q <= 1'b0;
      inst_o      <= NOP_INST;
      pc_o        <= '0;
      valid_o     <= 1'b0;
    end else begin
      inst_o  <= NOP_INST;
      pc_o    <= '0;
      valid_o <= 1'b0;

      case (state_q)
        REQ: begin
          if (redirect_valid_i) begin
            pc_q <= redirect_target;
            if (imem_gnt_i) begin
              state_q <= WAIT;
              kill_q  <= 1'b1;
            end
          end else if (imem_gnt_i) begin
            state_q <= WAIT;
          end
        end

        WAIT: begin
          if (imem_rvalid_i) begin
            if (redirect_valid_i || kill_q) begin
              kill_q  <= 1'b0;
              state_q <= REQ;
              if (redirect_valid_i) begin
                pc_q <= redirect_target;
              end
            end else if (!stall_i) begin
              inst_o  <= imem_rdata_i;
              pc_o    <= pc_next_seq;
              valid_o <= 1'b1;
              pc_q    <= pc_next_seq;
              state_q <= REQ;
            end else begin
              hold_word_q <= imem_rdata_i;
              hold_full_q <= 1'b1;
              state_q     <= HOLD;
            end
          end else if (redirect_valid_i) begin
            kill_q <= 1'b1;
            pc_q   <= redirect_target;
          end
        end

        HOLD: begin
          if (redirect_valid_i) begin
            pc_q        <= redirect_target;
            hold_full_q <= 1'b0;
            state_q     <= REQ;
          end else if (!stall_i && hold_full_q) begin
            inst_o      <= hold_word_q;
            pc_o        <= pc_next_seq;
            valid_o     <= 1'b1;
            pc_q        <= pc_next_seq;
            hold_full_q <= 1'b0;
            state_q     <= REQ;
          end
        end

        default: begin
          state_q     <= REQ;
          kill_q      <= 1'b0;
          hold_full_q <= 1'b0;
        end
      endcase
    end
  end

  // A response outside WAIT means the memory broke the one-outstanding protocol.
  a_rvalid_only_in_wait: assert property (
    @(posedge clk) disable iff (rst) imem_rvalid_i |-> (state_q == WAIT)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed per-cycle vector bench for fetch_stage.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        stall_i;
  logic        redirect_valid_i;
  logic [31:0] redirect_pc_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        valid_o;

  localparam logic [31:0] NOP = 32'h0000_0000;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_o       (imem_req_o),
    .imem_addr_o      (imem_addr_o),
    .imem_gnt_i       (imem_gnt_i),
    .imem_rvalid_i    (imem_rvalid_i),
    .imem_rdata_i     (imem_rdata_i),
    .stall_i          (stall_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .inst_o           (inst_o),
    .pc_o             (pc_o),
    .valid_o          (valid_o)
  );

  // One record per cycle: inputs for the cycle, req/addr seen before the edge,
  // registered outputs seen after the edge.
  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                     input logic stall, input logic redir, input logic [31:0] rpc,
                     input logic exp_req, input logic [31:0] exp_addr,
                     input logic exp_valid, input logic [31:0] exp_inst,
                     input logic [31:0] exp_pc);
    vecs.push_back('{gnt, rvalid, rdata, stall, redir, rpc,
                     exp_req, exp_addr, exp_valid, exp_inst, exp_pc});
  endtask

  initial begin
    rst = 1'b1;
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i = '0;
    stall_i = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i = '0;

    //   gnt rv rdata          st rd rpc           req addr          v  inst           pc
    // 1-cycle memory at addr 0, then addr 4
    add(1, 0, 32'h0,          0, 0, 32'h0,        1, 32'h0000_0000, 0, NOP,          32'h0);
    add(0, 1, 32'h2408_0005,  0, 0, 32'h0,        0, 32'h0000_0000, 1, 32'h2408_0005, 32'h4);
    add(1, 0, 32'h0,          0, 0, 32'h0,        1, 32'h0000_0004, 0, NOP,          32'h0);
    add(0, 1, 32'h2009_0007,  0, 0, 32'h0,        0, 32'h0000_0004, 1, 32'h2009_0007, 32'h8);
    // grant delayed 3 cycles at addr 8, rvalid one cycle after grant+1
    add(0, 0, 32'h0,          0, 0, 32'h0,        1, 32'h0000_0008, 0, NOP,          32'h0);
    add(0, 0, 32'h0,          0, 0, 32'h0,        1, 32'h0000_0008, 0, NOP,          32'h0);
    add(0, 0, 32'h0,          0, 0, 32'h0,        1, 32'h0000_0008, 0, NOP,          32'h0);
    add(1, 0, 32'h0,          0, 0, 32'h0,        1, 32'h0000_0008, 0, NOP,          32'h0);
    add(0, 0, 32'h0,          0, 0, 32'h0,        0, 32'h0000_0008, 0, NOP,          32'h0);
    add(0, 1, 32'h012A_5820,  0, 0, 32'h0,        0, 32'h0000_0008, 1, 32'h012A_5820, 32'hC);
    // stall for 4 cycles while addr 12 returns
    add(1, 0, 32'h0,          0, 0, 32'h0,        1, 32'h0000_000C, 0, NOP,          32'h0);
    add(0, 1, 32'h8D0B_0000,  1, 0, 32'h0,        0, 32'h0000_000C, 0, NOP,          32'h0);
    add(0, 0, 32'h0,          1, 0, 32'h0,        0, 32'h0000_000C, 0, NOP,          32'h0);
    add(0, 0, 32'h0,          1, 0, 32'h0,        0, 32'h0000_000C, 0, NOP,          32'h0);
    add(0, 0, 32'h0,          1, 0, 32'h0,        0, 32'h0000_000C, 0, NOP,          32'h0);
    add(0, 0, 32'h0,          0, 0, 32'h0,        0, 32'h0000_000C, 1, 32'h8D0B_0000, 32'h10);
    add(1, 0, 32'h0,          0, 0, 32'h0,        1, 32'h0000_0010, 0, NOP,          32'h0);
    add(0, 1, 32'hAD0C_0004,  0, 0, 32'h0,        0, 32'h0000_0010, 1, 32'hAD0C_0004, 32'h14);
    // redirect to 0x40 while waiting on addr 20
    add(1, 0, 32'h0,          0, 0, 32'h0,        1, 32'h0000_0014, 0, NOP,          32'h0);
    add(0, 0, 32'h0,          0, 1, 32'h0000_0040, 0, 32'h0000_0014, 0, NOP,          32'h0);
    add(0, 1, 32'hDEAD_BEEF,  0, 0, 32'h0,        0, 32'h0000_0040, 0, NOP,          32'h0);
    add(1, 0, 32'h0,          0, 0, 32'h0,        1, 32'h0000_0040, 0, NOP,          32'h0);
    add(0, 1, 32'h1000_FFFF,  0, 0, 32'h0,        0, 32'h0000_0040, 1, 32'h1000_FFFF, 32'h44);
    // redirect to 0x83 with rvalid and stall together
    add(1, 0, 32'h0,          0, 0, 32'h0,        1, 32'h0000_0044, 0, NOP,          32'h0);
    add(0, 1, 32'hBAD0_0001,  1, 1, 32'h0000_0083, 0, 32'h0000_0044, 0, NOP,          32'h0);
    add(0, 0, 32'h0,          0, 0, 32'h0,        1, 32'h0000_0080, 0, NOP,          32'h0);
    add(1, 0, 32'h0,          0, 0, 32'h0,        1, 32'h0000_0080, 0, NOP,          32'h0);
    add(0, 1, 32'h3C01_1234,  0, 0, 32'h0,        0, 32'h0000_0080, 1, 32'h3C01_1234, 32'h84);
    // redirect in REQ coinciding with grant: response must be killed
    add(1, 0, 32'h0,          0, 1, 32'h0000_0100, 1, 32'h0000_0084, 0, NOP,          32'h0);
    add(0, 1, 32'hBAD0_0002,  0, 0, 32'h0,        0, 32'h0000_0100, 0, NOP,          32'h0);
    add(0, 0, 32'h0,          0, 0, 32'h0,        1, 32'h0000_0100, 0, NOP,          32'h0);
    // redirect in REQ without grant, to the top word, then PC wraps to 0
    add(0, 0, 32'h0,          0, 1, 32'hFFFF_FFFC, 1, 32'h0000_0100, 0, NOP,          32'h0);
    add(1, 0, 32'h0,          0, 0, 32'h0,        1, 32'hFFFF_FFFC, 0, NOP,          32'h0);
    add(0, 1, 32'h0800_0000,  0, 0, 32'h0,        0, 32'hFFFF_FFFC, 1, 32'h0800_0000, 32'h0);
    // redirect while HOLD discards the buffered word
    add(1, 0, 32'h0,          0, 0, 32'h0,        1, 32'h0000_0000, 0, NOP,          32'h0);
    add(0, 1, 32'hAAAA_0001,  1, 0, 32'h0,        0, 32'h0000_0000, 0, NOP,          32'h0);
    add(0, 0, 32'h0,          1, 1, 32'h0000_0200, 0, 32'h0000_0000, 0, NOP,          32'h0);
    add(0, 0, 32'h0,          0, 0, 32'h0,        1, 32'h0000_0200, 0, NOP,          32'h0);
    // park a word in HOLD ahead of the mid-operation reset
    add(1, 0, 32'h0,          0, 0, 32'h0,        1, 32'h0000_0200, 0, NOP,          32'h0);
    add(0, 1, 32'h5555_AAAA,  1, 0, 32'h0,        0, 32'h0000_0200, 0, NOP,          32'h0);

    // reset state
    @(negedge clk);
    #1 check("reset_req_low", {31'b0, imem_req_o}, 32'd0);
    @(posedge clk);
    #1;
    check("reset_valid", {31'b0, valid_o}, 32'd0);
    check("reset_inst", inst_o, NOP);
    check("reset_pc_o", pc_o, 32'h0);
    check("reset_addr", imem_addr_o, 32'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst              = 1'b0;
      imem_gnt_i       = vecs[i].gnt;
      imem_rvalid_i    = vecs[i].rvalid;
      imem_rdata_i     = vecs[i].rdata;
      stall_i          = vecs[i].stall;
      redirect_valid_i = vecs[i].redir;
      redirect_pc_i    = vecs[i].rpc;
      #1;
      check($sformatf("v%0d_req", i), {31'b0, imem_req_o}, {31'b0, vecs[i].exp_req});
      check($sformatf("v%0d_addr", i), imem_addr_o, vecs[i].exp_addr);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid", i), {31'b0, valid_o}, {31'b0, vecs[i].exp_valid});
      check($sformatf("v%0d_inst", i), inst_o, vecs[i].exp_inst);
      check($sformatf("v%0d_pc_o", i), pc_o, vecs[i].exp_pc);
    end

    // reset while HOLD has a buffered word
    @(negedge clk);
    rst = 1'b1;
    imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0;
    stall_i = 1'b0;
    redirect_valid_i = 1'b0;
    #1 check("hold_rst_req_low", {31'b0, imem_req_o}, 32'd0);
    @(posedge clk);
    #1;
    check("hold_rst_valid", {31'b0, valid_o}, 32'd0);
    check("hold_rst_inst", inst_o, NOP);
    check("hold_rst_pc_o", pc_o, 32'h0);
    check("hold_rst_addr", imem_addr_o, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      rst = 1'b0;
      #1;
      check($sformatf("post_rst%0d_req", k), {31'b0, imem_req_o}, 32'd1);
      check($sformatf("post_rst%0d_addr", k), imem_addr_o, 32'h0);
      @(posedge clk);
      #1;
      check($sformatf("post_rst%0d_valid", k), {31'b0, valid_o}, 32'd0);
      check($sformatf("post_rst%0d_inst", k), inst_o, NOP);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
